// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

  // Adjust-select codes; each code equals the digit's index in mmss_t.
  localparam logic [1:0] SEL_SEC_R = 2'b00;
  localparam logic [1:0] SEL_SEC_L = 2'b01;
  localparam logic [1:0] SEL_MIN_R = 2'b10;
  localparam logic [1:0] SEL_MIN_L = 2'b11;

  localparam int TENS_MAX_DEF  = 5;
  localparam int UNITS_MAX_DEF = 9;

  localparam int NUM_DIGITS = 4;

  // [3]=min_l [2]=min_r [1]=sec_l [0]=sec_r
  typedef logic [NUM_DIGITS-1:0][3:0] mmss_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on an already-debounced level; one pulse per press.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: run/pause/adjust FSM with BCD cascade counter and digit load.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SEC_TENS_MAX = TENS_MAX_DEF,
  parameter int UNITS_MAX    = UNITS_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       btn_reset,
  input  logic       btn_pause,
  input  logic       adj,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  output logic [3:0] min_l,
  output logic [3:0] min_r,
  output logic [3:0] sec_l,
  output logic [3:0] sec_r,
  output logic       running,
  output logic       adj_active
);

  localparam int          NUM_BTN = 2;
  localparam logic [3:0]  TMAX    = 4'(SEC_TENS_MAX);
  localparam logic [3:0]  UMAX    = 4'(UNITS_MAX);
  localparam mmss_t       DMAX    = {TMAX, UMAX, TMAX, UMAX};

  // Button index 0 = reset, 1 = pause.
  logic [NUM_BTN-1:0] btn_lvl, btn_rise;
  assign btn_lvl = {btn_pause, btn_reset};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    rise_detect u_rise (
      .clk    (clk),
      .rst    (rst),
      .lvl_i  (btn_lvl[b]),
      .rise_o (btn_rise[b])
    );
  end

  logic reset_edge, pause_edge;
  assign reset_edge = btn_rise[0];
  assign pause_edge = btn_rise[1];

  sw_state_e state_q, state_d;
  mmss_t     dig_q, dig_d, dig_inc, dig_ld;
  logic      running_q, adj_active_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE:  if (adj) state_d = ST_ADJUST; else if (pause_edge) state_d = ST_RUN;
      ST_RUN:    if (adj) state_d = ST_ADJUST; else if (pause_edge) state_d = ST_PAUSE;
      ST_ADJUST: if (!adj) state_d = ST_PAUSE;
      default:   state_d = ST_PAUSE;
    endcase
  end

  // Ripple-carry BCD increment; digits already at max roll to 0 and carry on.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    dig_inc = dig_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (dig_q[i] >= DMAX[i]) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dig_ld = dig_q;
    case (sel)
      SEL_SEC_R: dig_ld[0] = clamp_digit(num, DMAX[0]);
      SEL_SEC_L: dig_ld[1] = clamp_digit(num, DMAX[1]);
      SEL_MIN_R: dig_ld[2] = clamp_digit(num, DMAX[2]);
      SEL_MIN_L: dig_ld[3] = clamp_digit(num, DMAX[3]);
      default:   dig_ld    = dig_q;
    endcase
  end

  always_comb begin
    dig_d = dig_q;
    if (reset_edge)                          dig_d = '0;
    else if (state_q == ST_ADJUST && tick_adj) dig_d = dig_ld;
    else if (state_q == ST_RUN && tick_1hz)    dig_d = dig_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PAUSE;
      dig_q        <= '0;
      running_q    <= 1'b0;
      adj_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dig_q        <= dig_d;
      running_q    <= (state_d == ST_RUN);
      adj_active_q <= (state_d == ST_ADJUST);
    end
  end

  assign min_l      = dig_q[3];
  assign min_r      = dig_q[2];
  assign sec_l      = dig_q[1];
  assign sec_r      = dig_q[0];
  assign running    = running_q;
  assign adj_active = adj_active_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with hand-computed MM:SS expectations.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, tick_adj = 1'b0;
  logic       btn_reset = 1'b0, btn_pause = 1'b0, adj = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] num = 4'd0;
  logic [3:0] min_l, min_r, sec_l, sec_r;
  logic       running, adj_active;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stopwatch_core dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .tick_adj   (tick_adj),
    .btn_reset  (btn_reset),
    .btn_pause  (btn_pause),
    .adj        (adj),
    .sel        (sel),
    .num        (num),
    .min_l      (min_l),
    .min_r      (min_r),
    .sec_l      (sec_l),
    .sec_r      (sec_r),
    .running    (running),
    .adj_active (adj_active)
  );

  wire [15:0] t = {min_l, min_r, sec_l, sec_r};

  // One clock; inputs set before it are sampled, outputs read 1 ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic sec_tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
  endtask

  task automatic load(input logic [1:0] s, input logic [3:0] n);
    sel = s; num = n; tick_adj = 1'b1; step(); tick_adj = 1'b0; step();
  endtask

  task automatic pause_press();
    btn_pause = 1'b1; step(); btn_pause = 1'b0; step();
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst_time", t, 16'h0000);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_adj", 16'(adj_active), 16'h0);
    rst = 1'b0;

    // Start, holding the button for several cycles must not toggle back
    btn_pause = 1'b1; step();
    chk("start_running", 16'(running), 16'h1);
    step(); step();
    chk("held_pause_one_edge", 16'(running), 16'h1);
    btn_pause = 1'b0; step();

    for (int i = 0; i < 10; i++) sec_tick();
    chk("ten_ticks", t, 16'h0010);
    chk("ten_ticks_running", 16'(running), 16'h1);

    // Adjust mode: clamping and tick_1hz ignored
    adj = 1'b1; step();
    chk("adj_enter", 16'(adj_active), 16'h1);
    chk("adj_not_running", 16'(running), 16'h0);
    load(2'b01, 4'd12);
    chk("clamp_sec_l", t, 16'h0050);
    load(2'b00, 4'd7);
    chk("load_sec_r", t, 16'h0057);
    sec_tick();
    chk("adj_no_count", t, 16'h0057);
    chk("adj_still_active", 16'(adj_active), 16'h1);

    // Preload 59:59 (sec_r clamps 15 -> 9, sec_l clamps 9 -> 5)
    load(2'b11, 4'd5);
    load(2'b10, 4'd9);
    load(2'b01, 4'd9);
    load(2'b00, 4'd15);
    chk("preload_5959", t, 16'h5959);
    adj = 1'b0; step();
    chk("adj_exit_pause", 16'({running, adj_active}), 16'h0);
    sec_tick();
    chk("pause_no_count", t, 16'h5959);
    pause_press();
    chk("rerun", 16'(running), 16'h1);
    sec_tick();
    chk("wrap_0000", t, 16'h0000);

    // Clear coincident with a count tick
    for (int i = 0; i < 42; i++) sec_tick();
    chk("count_42", t, 16'h0042);
    btn_reset = 1'b1; tick_1hz = 1'b1; step();
    chk("clear_beats_tick", t, 16'h0000);
    chk("clear_keeps_run", 16'(running), 16'h1);
    step();
    chk("held_clear_counts", t, 16'h0001);
    btn_reset = 1'b0; tick_1hz = 1'b0; step();

    // adj beats a same-cycle pause edge; pause edges ignored in ADJUST
    adj = 1'b1; btn_pause = 1'b1; step();
    chk("adj_prio", 16'({running, adj_active}), 16'h1);
    btn_pause = 1'b0; step();
    for (int i = 0; i < 3; i++) pause_press();
    chk("adj_ignores_pause", 16'({running, adj_active}), 16'h1);

    // Preload 12:34, run, then reset mid-run alongside a tick
    load(2'b11, 4'd1);
    load(2'b10, 4'd2);
    load(2'b01, 4'd3);
    load(2'b00, 4'd4);
    adj = 1'b0; step();
    chk("adj0_pause", 16'({running, adj_active}), 16'h0);
    pause_press();
    chk("run_1234", t, 16'h1234);
    rst = 1'b1; tick_1hz = 1'b1; step();
    chk("rst_midrun_time", t, 16'h0000);
    chk("rst_midrun_running", 16'(running), 16'h0);
    tick_1hz = 1'b0;

    // Pause button already high through reset release -> one edge only
    btn_pause = 1'b1; step();
    rst = 1'b0; step();
    chk("rel_held_edge", 16'(running), 16'h1);
    step(); step();
    chk("rel_held_single", 16'(running), 16'h1);
    btn_pause = 1'b0; step();

    // Mid cascade carry 09:59 -> 10:00
    adj = 1'b1; step();
    load(2'b11, 4'd0);
    load(2'b10, 4'd9);
    load(2'b01, 4'd5);
    load(2'b00, 4'd9);
    adj = 1'b0; step();
    pause_press();
    sec_tick();
    chk("carry_1000", t, 16'h1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter SEC_TENS_MAX, default 5, giving the maximum value of the seconds-tens and minutes-tens digits.
REQ-002 SHALL have parameter UNITS_MAX, default 9, giving the maximum value of the seconds-units and minutes-units digits.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tick_1hz, input, 1 bit: one-clk pulse at 1 Hz; the count advance enable.
REQ-006 SHALL have port tick_adj, input, 1 bit: one-clk pulse at the adjust rate (5 Hz); the digit-load enable.
REQ-007 SHALL have port btn_reset, input, 1 bit: debounced level; each rising edge clears the time.
REQ-008 SHALL have port btn_pause, input, 1 bit: debounced level; each rising edge toggles run/pause.
REQ-009 SHALL have port adj, input, 1 bit: adjust-mode level switch.
REQ-010 SHALL have port sel, input, 2 bits: adjust digit select; 00 sec_r, 01 sec_l, 10 min_r, 11 min_l.
REQ-011 SHALL have port num, input, 4 bits: binary value loaded into the selected digit.
REQ-012 SHALL have ports min_l, min_r, sec_l, sec_r, output, 4 bits each: registered BCD digits.
REQ-013 SHALL have port running, output, 1 bit: high only in state RUN.
REQ-014 SHALL have port adj_active, output, 1 bit: high only in state ADJUST; consumed by the display for blinking.

Function
REQ-015 SHALL implement a 3-state FSM with states PAUSE, RUN and ADJUST.
REQ-016 SHALL detect button rising edges with a registered previous-level copy; an edge is cur=1, prev=0, so a held button yields exactly one edge.
REQ-017 SHALL use these FSM transitions: PAUSE→RUN and RUN→PAUSE on a btn_pause edge; PAUSE/RUN→ADJUST when adj=1; ADJUST→PAUSE when adj=0.
REQ-018 SHALL ignore btn_pause edges while adj=1, and SHALL give adj priority over a pause edge in the same cycle.
REQ-019 SHALL, in RUN on tick_1hz, increment MM:SS as a BCD cascade: sec_r 9→0 carries to sec_l; sec_l 5→0 carries to min_r; min_r 9→0 carries to min_l; 59:59 wraps to 00:00.
REQ-020 SHALL leave the digits unchanged on tick_1hz in PAUSE or ADJUST.
REQ-021 SHALL, in ADJUST on tick_adj, load num into the digit chosen by sel, clamped to that digit's maximum (e.g. num=12 into sec_l gives 5; num=12 into sec_r gives 9).
REQ-022 SHALL, on a btn_reset edge, clear all four digits to 0 in any state and SHALL leave the FSM state unchanged.
REQ-023 SHALL apply update priority per cycle, highest first: rst, btn_reset edge, adjust load, count increment.
REQ-024 SHALL update digits the cycle after the qualifying tick or edge (latency 1 clk); the FSM state seen in the tick cycle decides the action, and a transition takes effect the next cycle.
REQ-025 SHALL keep digit values within legal BCD range at all times; no out-of-range digit SHALL ever appear on the outputs.
REQ-026 SHALL have all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, when rst=1 at a clk edge, set state PAUSE, all digits 0, running=0, adj_active=0, and edge-detect history registers to 0.
REQ-028 SHALL make reset override every other input in the same cycle, including mid-count and mid-adjust.
REQ-029 SHALL, when reset releases with btn_pause already high, produce a single edge only.

Structure
REQ-030 SHALL take the state encoding, the sel digit codes and the digit-maximum constants from shared package stopwatch_pkg.
REQ-031 SHALL use one sub-module, rise_detect, instantiated once per button.
REQ-032 SHALL contain no clock division; tick pulses come from the clock divider.

Verification
REQ-033 SHALL cover: reset, btn_pause edge, 10 tick_1hz pulses → running=1, digits 00:10.
REQ-034 SHALL cover: preload 59:59 via adjust, run, one tick_1hz → 00:00.
REQ-035 SHALL cover: adj=1, sel=01, num=12, one tick_adj → sec_l=5; sel=00, num=7, tick_adj → sec_r=7; adj_active=1 throughout.
REQ-036 SHALL cover: RUN at 00:42, btn_reset edge in the same cycle as tick_1hz → 00:00, running stays 1.
REQ-037 SHALL cover: adj=1 while btn_pause toggles 3 times → state stays ADJUST; adj=0 → PAUSE, running=0.
REQ-038 SHALL cover: rst asserted mid-RUN at 12:34 → next cycle 00:00, running=0.
